// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bundle shared by the VGA timing generator and its pixel/DAC consumers.
interface vga_timing_ctrl_if;
  logic       pix_en;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       bright;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  modport master (
    output pix_en, hcount, vcount, bright, hsync, vsync, frame_start
  );

  modport slave (
    input pix_en, hcount, vcount, bright, hsync, vsync, frame_start
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel-rate enable, h/v counters and registered bright/sync/frame_start.
module vga_timing_ctrl #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_ctrl_if.master vga
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_en_q, pix_en_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic             bright_q, bright_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_start_q, frame_start_d;

  always_comb begin
    div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    pix_en_d      = (div_cnt_q == DIV_LAST);
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    bright_d      = bright_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;

    if (pix_en_q) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
      end

      // Decoded from the next counts so outputs line up with the counters they describe.
      bright_d = (hcount_d < H_VIS_L) && (vcount_d < V_VIS_L);
      hsync_d  = !((hcount_d >= HS_START) && (hcount_d < HS_END));
      vsync_d  = !((vcount_d >= VS_START) && (vcount_d < VS_END));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q     <= '0;
      pix_en_q      <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      bright_q      <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_en_q      <= pix_en_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      bright_q      <= bright_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pix_en      = pix_en_q;
  assign vga.hcount      = hcount_q;
  assign vga.vcount      = vcount_q;
  assign vga.bright      = bright_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: full-size, shrunken-frame and CLK_DIV=1 builds on one clock.
module tb_vga_timing_ctrl;

  logic clk;
  logic reset;
  int   n;          // rising edges since reset release
  int   checks;
  int   failures;

  vga_timing_ctrl_if if_d ();
  vga_timing_ctrl_if if_s ();
  vga_timing_ctrl_if if_1 ();

  vga_timing_ctrl u_dut_def (.clk(clk), .reset(reset), .vga(if_d.master));

  vga_timing_ctrl #(
    .CLK_DIV(2), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut_small (.clk(clk), .reset(reset), .vga(if_s.master));

  vga_timing_ctrl #(.CLK_DIV(1)) u_dut_div1 (.clk(clk), .reset(reset), .vga(if_1.master));

  logic [24:0] obs_d, obs_s, obs_1;
  assign obs_d = {if_d.pix_en, if_d.hcount, if_d.vcount, if_d.bright, if_d.hsync, if_d.vsync, if_d.frame_start};
  assign obs_s = {if_s.pix_en, if_s.hcount, if_s.vcount, if_s.bright, if_s.hsync, if_s.vsync, if_s.frame_start};
  assign obs_1 = {if_1.pix_en, if_1.hcount, if_1.vcount, if_1.bright, if_1.hsync, if_1.vsync, if_1.frame_start};

  localparam logic [24:0] RST_VAL = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  // Closed-form expectation after edge n: steps land on edges cd+1, 2cd+1, ...
  function automatic logic [24:0] exp_out(input int en, input int cd,
                                          input int hv, input int hf, input int hs, input int hb,
                                          input int vv, input int vf, input int vs, input int vb);
    int ht, vt, steps, p, h, v;
    logic pe, br, hsy, vsy, fs;
    ht    = hv + hf + hs + hb;
    vt    = vv + vf + vs + vb;
    steps = (en > cd) ? (en - 1) / cd : 0;
    p     = steps % (ht * vt);
    h     = p % ht;
    v     = p / ht;
    pe    = (en >= cd) && (en % cd == 0);
    br    = (steps > 0) && (h < hv) && (v < vv);
    hsy   = !((h >= hv + hf) && (h < hv + hf + hs));
    vsy   = !((v >= vv + vf) && (v < vv + vf + vs));
    fs    = (en > cd) && ((en - 1) % cd == 0) && (steps > 0) && (p == 0);
    return {pe, 10'(h), 10'(v), br, hsy, vsy, fs};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 3;
      if (obs_d !== RST_VAL) begin failures++; $display("FAIL reset_def actual=%h expected=%h", obs_d, RST_VAL); end
      if (obs_s !== RST_VAL) begin failures++; $display("FAIL reset_small actual=%h expected=%h", obs_s, RST_VAL); end
      if (obs_1 !== RST_VAL) begin failures++; $display("FAIL reset_div1 actual=%h expected=%h", obs_1, RST_VAL); end
    end
    reset = 1'b0;
  endtask

  task automatic test_first_steps();
    tick();
    checks++;
    if (if_d.pix_en !== 1'b0 || if_d.hcount !== 10'd0) begin
      failures++; $display("FAIL edge1 actual pix_en=%b hcount=%0d expected pix_en=0 hcount=0", if_d.pix_en, if_d.hcount);
    end
    tick();
    checks++;
    if (if_d.pix_en !== 1'b1 || if_d.bright !== 1'b0 || if_d.hcount !== 10'd0) begin
      failures++; $display("FAIL edge2 actual pix_en=%b bright=%b hcount=%0d expected 1 0 0", if_d.pix_en, if_d.bright, if_d.hcount);
    end
    tick();
    checks++;
    if (if_d.pix_en !== 1'b0 || if_d.bright !== 1'b1 || if_d.hcount !== 10'd1 || if_d.vcount !== 10'd0) begin
      failures++; $display("FAIL first_step actual pix_en=%b bright=%b h=%0d v=%0d expected 0 1 1 0",
                           if_d.pix_en, if_d.bright, if_d.hcount, if_d.vcount);
    end
  endtask

  task automatic test_line();
    logic [24:0] e;
    int hs_low = 0;
    int printed = 0;
    while (n < 1700) begin
      tick();
      e = exp_out(n, 2, 640, 16, 96, 48, 480, 10, 2, 33);
      checks++;
      if (obs_d !== e) begin
        failures++;
        if (printed++ < 10) $display("FAIL line_def n=%0d actual=%h expected=%h", n, obs_d, e);
      end
      if (n <= 1602 && if_d.hsync === 1'b0) hs_low++;
    end
    checks++;
    if (hs_low !== 192) begin failures++; $display("FAIL hsync_width actual=%0d expected=192", hs_low); end
  endtask

  task automatic test_small_frames();
    logic [24:0] e;
    int fs_cnt = 0;
    int vs_low = 0;
    int printed = 0;
    bit fs_prev = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      e = exp_out(n, 2, 16, 2, 4, 3, 8, 2, 2, 3);
      checks++;
      if (obs_s !== e) begin
        failures++;
        if (printed++ < 10) $display("FAIL frame_small n=%0d actual=%h expected=%h", n, obs_s, e);
      end
      checks++;
      if (fs_prev && if_s.frame_start === 1'b1) begin
        failures++; $display("FAIL frame_start_double n=%0d actual=1 expected=0", n);
      end
      fs_prev = (if_s.frame_start === 1'b1);
      if (if_s.frame_start === 1'b1) fs_cnt++;
      if (if_s.vsync === 1'b0) vs_low++;
    end
    checks += 2;
    if (fs_cnt !== 2)   begin failures++; $display("FAIL frame_start_count actual=%0d expected=2", fs_cnt); end
    if (vs_low !== 200) begin failures++; $display("FAIL vsync_width actual=%0d expected=200", vs_low); end
  endtask

  task automatic test_div1();
    logic [24:0] e;
    int hs_low = 0;
    int printed = 0;
    for (int i = 0; i < 1600; i++) begin
      tick();
      e = exp_out(n, 1, 640, 16, 96, 48, 480, 10, 2, 33);
      checks++;
      if (obs_1 !== e) begin
        failures++;
        if (printed++ < 10) $display("FAIL div1 n=%0d actual=%h expected=%h", n, obs_1, e);
      end
      if (if_1.hsync === 1'b0) hs_low++;
    end
    checks++;
    if (hs_low !== 192) begin failures++; $display("FAIL div1_hsync_width actual=%0d expected=192", hs_low); end
  endtask

  task automatic test_midframe_reset();
    logic [24:0] e;
    int first_fs = -1;
    int second_fs = -1;
    int printed = 0;
    reset = 1'b1;
    #1;
    checks += 3;
    if (obs_d !== RST_VAL) begin failures++; $display("FAIL async_reset_def actual=%h expected=%h", obs_d, RST_VAL); end
    if (obs_s !== RST_VAL) begin failures++; $display("FAIL async_reset_small actual=%h expected=%h", obs_s, RST_VAL); end
    if (obs_1 !== RST_VAL) begin failures++; $display("FAIL async_reset_div1 actual=%h expected=%h", obs_1, RST_VAL); end
    tick();
    reset = 1'b0;
    // 375-pixel small frame: wrap is step 375, landing on edge 2*375+1.
    while (second_fs < 0 && n < 2000) begin
      tick();
      e = exp_out(n, 2, 16, 2, 4, 3, 8, 2, 2, 3);
      checks++;
      if (obs_s !== e) begin
        failures++;
        if (printed++ < 10) $display("FAIL restart_small n=%0d actual=%h expected=%h", n, obs_s, e);
      end
      if (if_s.frame_start === 1'b1) begin
        if (first_fs < 0) first_fs = n;
        else              second_fs = n;
      end
    end
    checks += 2;
    if (first_fs !== 751)  begin failures++; $display("FAIL first_frame_start actual=%0d expected=751", first_fs); end
    if (second_fs !== 1501) begin failures++; $display("FAIL second_frame_start actual=%0d expected=1501", second_fs); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    test_reset();
    test_first_steps();
    test_line();
    test_small_frames();
    test_div1();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
